latch_write_arbiter: RTL and testbench

// - Shares one WIDTH-bit level-sensitive storage word (bank of D-latches) among
//   NUM_REQ requesters. Arbitrates, sequences the latch enable, and reports completion.
// - Sits between requester FSMs and the latch bank.
// - Guarantees that D is stable for the whole time En is high, and that only one

---
 rtl/latch_write_arbiter.sv | 112 +++++++++++
 tb/tb_latch_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_write_arbiter.sv
// Arbitrates NUM_REQ writers onto one latch word and sequences its enable.
// Define FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module latch_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*WIDTH-1:0] D_bus,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     En,
    output logic [WIDTH-1:0]         D,
    output logic [WIDTH-1:0]         Q,
    output logic                     Done,
    output logic                     Busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] holdCnt;
    logic [IDX_W-1:0] winIdx;

`ifdef FIXED_PRIORITY_EN
    always_comb begin
        winIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req[IDX_W'(i)]) winIdx = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] owner;
    int               cand;

    // Scan downward so the smallest offset past rrPtr is the last to win.
    always_comb begin
        winIdx = '0;
        cand   = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(rrPtr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (Req[IDX_W'(cand)]) winIdx = IDX_W'(cand);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rrPtr <= IDX_W'(NUM_REQ - 1);
            owner <= '0;
        end else if (state == IDLE && |Req) begin
            owner <= winIdx;
        end else if (state == COMMIT) begin
            rrPtr <= owner;
        end
    end
`endif

    // Every output is a flop, so En cannot glitch and D is frozen while it is high.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= IDLE;
            holdCnt <= '0;
            Grant   <= '0;
            En      <= 1'b0;
            D       <= '0;
            Q       <= '0;
            Done    <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Req) begin
                        state   <= WRITE;
                        Grant   <= NUM_REQ'(1) << winIdx;
                        D       <= D_bus[winIdx*WIDTH +: WIDTH];
                        En      <= 1'b1;
                        Busy    <= 1'b1;
                        holdCnt <= CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                WRITE: begin
                    if (holdCnt == '0) begin
                        state <= COMMIT;
                        En    <= 1'b0;
                        Done  <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt - CNT_W'(1);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    Grant <= '0;
                    Q     <= D;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Randomized bench for latch_write_arbiter against a time-based write model.
// Directed cases cover ordering, data snapshot, async abort and handshake.
module tb_latch_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    logic           Clk   = 1'b0;
    logic           Rst_n = 1'b0;
    logic [N-1:0]   Req   = '0;
    logic [N*W-1:0] D_bus = '0;
    logic [N-1:0]   Grant;
    logic           En;
    logic [W-1:0]   D;
    logic [W-1:0]   Q;
    logic           Done;
    logic           Busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit           mBusy;
    int           mAge;
    int           mWin;
    int           mLast;
    logic [W-1:0] mData;
    logic [W-1:0] mQ;

    int doneGrant[$];
    int doneCyc[$];

    always #5 Clk = ~Clk;

    latch_write_arbiter #(
        .NUM_REQ(N),
        .WIDTH(W),
        .HOLD_CYCLES(H)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Req(Req),
        .D_bus(D_bus),
        .Grant(Grant),
        .En(En),
        .D(D),
        .Q(Q),
        .Done(Done),
        .Busy(Busy)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hasReq(logic [N-1:0] r, int idx);
        logic [N-1:0] sel;
        sel = N'(1) << idx;
        return (r & sel) != '0;
    endfunction

    function automatic int pick(logic [N-1:0] r, int last);
`ifdef FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++)
            if (hasReq(r, i)) return i;
`else
        for (int off = 1; off <= N; off++)
            if (hasReq(r, (last + off) % N)) return (last + off) % N;
`endif
        return 0;
    endfunction

    task automatic modelReset();
        mBusy = 1'b0;
        mAge  = 0;
        mWin  = 0;
        mLast = N - 1;
        mData = '0;
        mQ    = '0;
    endtask

    // A write occupies HOLD cycles of En, one Done cycle, then one idle cycle.
    task automatic cycle();
        @(posedge Clk);
        cyc++;
        if (!mBusy) begin
            if (Req != '0) begin
                mWin  = pick(Req, mLast);
                mData = D_bus[mWin*W +: W];
                mBusy = 1'b1;
                mAge  = 0;
            end
        end else begin
            mAge++;
            if (mAge == H + 1) begin
                mBusy = 1'b0;
                mQ    = mData;
                mLast = mWin;
            end
        end
        #1;
        check("grant", 32'(Grant), mBusy ? (32'd1 << mWin) : 32'd0);
        check("busy", 32'(Busy), 32'(mBusy));
        check("en", 32'(En), 32'(mBusy && mAge < H));
        check("done", 32'(Done), 32'(mBusy && mAge == H));
        check("d", 32'(D), 32'(mData));
        check("q", 32'(Q), 32'(mQ));
        if (Done) begin
            doneGrant.push_back(int'(Grant));
            doneCyc.push_back(cyc);
        end
    endtask

    task automatic doReset();
        Rst_n = 1'b0;
        modelReset();
        #7;
        Rst_n = 1'b1;
    endtask

    initial begin
        int exp4[5];
        modelReset();
        #12;
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_en", 32'(En), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        Rst_n = 1'b1;

        // single write from requester 0
        Req = 4'b0001;
        D_bus[7:0] = 8'hA5;
        repeat (3) cycle();
        Req = '0;
        cycle();
        check("t1_q", 32'(Q), 32'h0000_00A5);

        // all requesters held: rotation and Done spacing
        doReset();
        doneGrant.delete();
        doneCyc.delete();
        Req = 4'b1111;
        D_bus = 32'h4433_2211;
        repeat (20) cycle();
        Req = '0;
        cycle();
`ifdef FIXED_PRIORITY_EN
        exp4 = '{1, 1, 1, 1, 1};
`else
        exp4 = '{1, 2, 4, 8, 1};
`endif
        check("t2_ndone", 32'(doneGrant.size()), 32'd5);
        for (int i = 0; i < 5 && i < doneGrant.size(); i++)
            check("t2_order", 32'(doneGrant[i]), 32'(exp4[i]));
        for (int i = 1; i < doneCyc.size(); i++)
            check("t2_space", 32'(doneCyc[i] - doneCyc[i-1]), 32'(H + 2));

        // data snapshot survives D_bus change during the write
        Req = 4'b0100;
        D_bus[23:16] = 8'h3C;
        cycle();
        D_bus[23:16] = 8'hFF;
        repeat (2) cycle();
        Req = '0;
        cycle();
        check("t3_q", 32'(Q), 32'h0000_003C);

        // async reset mid-write
        Req = 4'b1111;
        repeat (2) cycle();
        #2;
        Rst_n = 1'b0;
        #1;
        check("t4_en", 32'(En), 32'd0);
        check("t4_grant", 32'(Grant), 32'd0);
        check("t4_busy", 32'(Busy), 32'd0);
        check("t4_done", 32'(Done), 32'd0);
        check("t4_q", 32'(Q), 32'd0);
        modelReset();
        #2;
        Rst_n = 1'b1;
        cycle();
        check("t4_regrant", 32'(Grant), 32'd1);
        repeat (3) cycle();
        Req = '0;
        cycle();

        // requester 1 drops Req mid-write; its write still commits
        doReset();
        Req = 4'b1010;
        D_bus = 32'h8877_6655;
        cycle();
        check("t5_g1", 32'(Grant), 32'b0010);
        Req = 4'b1000;
        repeat (3) cycle();
        check("t5_q", 32'(Q), 32'h0000_0066);
        cycle();
        check("t5_g3", 32'(Grant), 32'b1000);
        Req = '0;
        repeat (4) cycle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            Req = N'($urandom_range(0, (1 << N) - 1));
            if ($urandom_range(0, 3) == 0) Req = '0;
            D_bus = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
